// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- RV32I instruction-fetch stage.
//
// Owns the PC, issues one word fetch at a time over a req/ack memory port
// and presents the fetched instruction at the IF/ID boundary. No prefetch:
// with a zero-wait memory one instruction is delivered every two cycles.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   stall[5:0]       bit0 = hold PC / fetch launch, bit1 = hold IF outputs
//   br_taken         one-cycle redirect pulse, highest priority
//   br_target        redirect address (low two bits ignored)
//   mem_req/addr     registered fetch request, address stable while req=1
//   mem_ack/rdata    fetch completion and returned word
//   if_pc/inst/valid registered instruction presented downstream
//   if_stall_req     combinational: no instruction can be supplied next edge
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid,
  output logic              if_stall_req
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;

  logic              deliver;
  logic [INST_W-1:0] dlv_inst;

  // Only the two low stall bits concern this stage.
  logic hold_launch;
  logic hold_if;
  logic unused_stall;

  assign hold_launch  = stall[0];
  assign hold_if      = stall[1];
  assign unused_stall = ^stall[5:2];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!br_taken && !hold_launch) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Without ack a redirect just arms drop and keeps waiting.
        if (mem_ack) begin
          if (drop_q || br_taken || !hold_if) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (br_taken || !hold_if) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic.
  always_comb begin
    pc_d         = pc_q;
    drop_d       = drop_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_valid_d   = if_valid_q;
    deliver      = 1'b0;
    dlv_inst     = buf_q;

    unique case (state_q)
      S_IDLE: begin
        if (!br_taken && !hold_launch) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A stale (dropped) response or one racing a redirect is discarded.
          if (!drop_q && !br_taken) begin
            pc_d = pc_q + ADDR_W'(4);
            if (!hold_if) begin
              deliver  = 1'b1;
              dlv_inst = mem_rdata;
            end else begin
              buf_d       = mem_rdata;
              buf_valid_d = 1'b1;
            end
          end
        end else if (br_taken) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (!br_taken && !hold_if && buf_valid_q) begin
          deliver     = 1'b1;
          dlv_inst    = buf_q;
          buf_valid_d = 1'b0;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase

    // Redirect overrides the PC and flushes any buffered word.
    if (br_taken) begin
      pc_d        = {br_target[ADDR_W-1:2], 2'b00};
      buf_valid_d = 1'b0;
    end

    // IF outputs: flushed on redirect, otherwise updated only when not held.
    // mem_addr_q still holds the delivered word's fetch address in WAIT/HOLD.
    if (br_taken) begin
      if_valid_d = 1'b0;
    end else if (!hold_if) begin
      if_valid_d = deliver;
      if (deliver) begin
        if_inst_d = dlv_inst;
        if_pc_d   = mem_addr_q;
      end
    end

    if_stall_req = !rst &&
                   ((state_q == S_IDLE) ||
                    ((state_q == S_WAIT) && (!mem_ack || drop_q)));
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- bench for if_fetch: table of fetch transactions plus
// hand-written redirect / reset / wrap / dual-stall sequences. Delivered
// instructions are matched against a queue of expected {pc, inst}.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_stall_req;

  if_fetch #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid),
    .if_stall_req(if_stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned lat;
    int unsigned hold;
    logic [31:0] data;
  } vec_t;

  exp_t        sb[$];
  int unsigned del_cyc[$];
  int unsigned cyc_n;
  int          checks;
  int          errors;
  logic        upd_edge;
  vec_t        tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Cycle counter and whether the last edge was an IF-output update edge.
  always @(posedge clk) begin
    cyc_n    <= cyc_n + 1;
    upd_edge <= !rst && (!stall[1] || br_taken);
  end

  // Scoreboard: every fresh delivery must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (upd_edge && if_valid) begin
      del_cyc.push_back(cyc_n);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %0h inst %0h, expected none", if_pc, if_inst);
      end else begin
        e = sb.pop_front();
        chk("deliver_pc", 64'(if_pc), 64'(e.pc));
        chk("deliver_inst", 64'(if_inst), 64'(e.inst));
      end
    end
  end

  // Wait (bounded) for a launched request and check its address.
  task automatic wait_req(input logic [31:0] ea);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      cyc();
      n++;
    end
    chk("req_seen", 64'(mem_req), 64'(1));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
  endtask

  // One fetch: lat wait cycles, then ack; stall[1] held for hold cycles
  // starting at the ack cycle (if_* must stay frozen at frz_pc, invalid).
  task automatic fetch(input logic [31:0] ea, input int unsigned lat,
                       input int unsigned hold, input logic [31:0] d,
                       input logic [31:0] frz_pc);
    wait_req(ea);
    for (int i = 0; i < int'(lat); i++) begin
      #1;
      chk("wait_stall_req", 64'(if_stall_req), 64'(1));
      chk("wait_req_held", 64'(mem_req), 64'(1));
      chk("wait_addr_held", 64'(mem_addr), 64'(ea));
      cyc();
    end
    stall[1]  = (hold > 0);
    mem_ack   = 1'b1;
    mem_rdata = d;
    sb.push_back({ea, d});
    #1;
    chk("ack_stall_req", 64'(if_stall_req), 64'(0));
    cyc();
    mem_ack = 1'b0;
    for (int i = 1; i < int'(hold); i++) begin
      #1;
      chk("hold_stall_req", 64'(if_stall_req), 64'(0));
      chk("hold_req", 64'(mem_req), 64'(0));
      chk("hold_if_pc", 64'(if_pc), 64'(frz_pc));
      chk("hold_if_valid", 64'(if_valid), 64'(0));
      cyc();
    end
    stall[1] = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc_n     = 0;
    upd_edge  = 1'b0;
    rst       = 1'b1;
    stall     = 6'b101000;
    br_taken  = 1'b0;
    br_target = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    tbl[0] = '{addr: 32'h0000_0000, lat: 0, hold: 0, data: 32'h0000_0013};
    tbl[1] = '{addr: 32'h0000_0004, lat: 0, hold: 0, data: 32'h0000_0013};
    tbl[2] = '{addr: 32'h0000_0008, lat: 0, hold: 0, data: 32'h0000_0013};
    tbl[3] = '{addr: 32'h0000_000C, lat: 3, hold: 0, data: 32'hDEAD_BEEF};
    tbl[4] = '{addr: 32'h0000_0010, lat: 0, hold: 4, data: 32'h1234_5678};
    tbl[5] = '{addr: 32'h0000_0014, lat: 1, hold: 0, data: 32'hCAFE_F00D};

    // Reset state
    repeat (3) cyc();
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_if_valid", 64'(if_valid), 64'(0));
    chk("rst_stall_req", 64'(if_stall_req), 64'(0));
    rst = 1'b0;
    #1;
    chk("idle_stall_req", 64'(if_stall_req), 64'(1));

    // Straight-line fetches, delayed ack, IF hold
    for (int i = 0; i < 6; i++) begin
      fetch(tbl[i].addr, tbl[i].lat, tbl[i].hold, tbl[i].data,
            (i > 0) ? tbl[i-1].addr : 32'h0);
    end
    chk("period_01", (del_cyc.size() >= 3) ? 64'(del_cyc[1] - del_cyc[0]) : 64'(0), 64'(2));
    chk("period_12", (del_cyc.size() >= 3) ? 64'(del_cyc[2] - del_cyc[1]) : 64'(0), 64'(2));

    // Redirect in WAIT before ack: response dropped, refetch at 0x100
    wait_req(32'h0000_0018);
    br_taken  = 1'b1;
    br_target = 32'h0000_0103;
    #1;
    chk("br_wait_stall_req", 64'(if_stall_req), 64'(1));
    cyc();
    br_taken = 1'b0;
    #1;
    chk("drop_valid", 64'(if_valid), 64'(0));
    chk("drop_req_held", 64'(mem_req), 64'(1));
    chk("drop_addr_held", 64'(mem_addr), 64'(32'h0000_0018));
    chk("drop_stall_req", 64'(if_stall_req), 64'(1));
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0018;
    #1;
    chk("drop_ack_stall_req", 64'(if_stall_req), 64'(1));
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("drop_req_clear", 64'(mem_req), 64'(0));
    fetch(32'h0000_0100, 0, 0, 32'h0010_0093, 32'h0);

    // Redirect together with ack: discard, no lingering drop
    wait_req(32'h0000_0104);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0104;
    br_taken  = 1'b1;
    br_target = 32'h0000_0200;
    #1;
    chk("br_ack_stall_req", 64'(if_stall_req), 64'(0));
    cyc();
    mem_ack  = 1'b0;
    br_taken = 1'b0;
    #1;
    chk("br_ack_req", 64'(mem_req), 64'(0));
    chk("br_ack_valid", 64'(if_valid), 64'(0));
    fetch(32'h0000_0200, 0, 0, 32'h0020_0113, 32'h0);

    // Redirect in HOLD: buffer flushed, if_valid cleared despite stall[1]
    stall[1] = 1'b1;
    wait_req(32'h0000_0204);
    #1;
    chk("hold_keep_valid", 64'(if_valid), 64'(1));
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0204;
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("hold5_stall_req", 64'(if_stall_req), 64'(0));
    chk("hold5_valid", 64'(if_valid), 64'(1));
    br_taken  = 1'b1;
    br_target = 32'h0000_0300;
    cyc();
    br_taken = 1'b0;
    #1;
    chk("flush_valid", 64'(if_valid), 64'(0));
    stall[1] = 1'b0;
    fetch(32'h0000_0300, 0, 0, 32'h0030_0193, 32'h0);

    // Reset mid-WAIT, then a stray ack
    wait_req(32'h0000_0304);
    rst = 1'b1;
    cyc();
    #1;
    chk("mid_rst_req", 64'(mem_req), 64'(0));
    chk("mid_rst_addr", 64'(mem_addr), 64'(0));
    chk("mid_rst_if_pc", 64'(if_pc), 64'(0));
    chk("mid_rst_if_inst", 64'(if_inst), 64'(0));
    chk("mid_rst_valid", 64'(if_valid), 64'(0));
    chk("mid_rst_stall_req", 64'(if_stall_req), 64'(0));
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0304;
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("stray_valid", 64'(if_valid), 64'(0));
    fetch(32'h0000_0000, 0, 0, 32'h0000_0297, 32'h0);

    // Redirect in IDLE (no launch that edge), then PC wrap
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFF;
    cyc();
    br_taken = 1'b0;
    #1;
    chk("br_idle_no_launch", 64'(mem_req), 64'(0));
    fetch(32'hFFFF_FFFC, 0, 0, 32'h0000_0073, 32'h0);
    fetch(32'h0000_0000, 0, 0, 32'h0040_0093, 32'h0);

    // Both stall bits: nothing launches, delivered word stays presented
    stall[1:0] = 2'b11;
    repeat (3) begin
      cyc();
      #1;
      chk("dual_no_launch", 64'(mem_req), 64'(0));
      chk("dual_stall_req", 64'(if_stall_req), 64'(1));
      chk("dual_hold_valid", 64'(if_valid), 64'(1));
    end
    stall[1:0] = 2'b00;
    fetch(32'h0000_0004, 0, 0, 32'h0050_0113, 32'h0);

    repeat (3) cyc();
    chk("sb_drain", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
